// File: rtl/iic_pkg.sv
// Shared types and bus constants for the MPU-6050 I2C master.
package iic_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StStart,
    StTxByte,
    StRxAck,
    StRestart,
    StRxByte,
    StTxNack,
    StStop,
    StDone
  } iic_state_e;

  localparam logic [3:0] SlavePrefix = 4'b1101;
  localparam logic       RwWrite     = 1'b0;
  localparam logic       RwRead      = 1'b1;

endpackage

// File: rtl/iic_clk_div.sv
// Quarter-bit tick generator with a 2-bit phase counter; held at phase 0 while clear is high.
module iic_clk_div #(
  parameter int unsigned Quarter = 125
) (
  input  logic       clk50M,
  input  logic       reset,
  input  logic       clear,
  output logic       tick,
  output logic [1:0] phase
);

  localparam int unsigned CntW = (Quarter > 1) ? $clog2(Quarter) : 1;

  logic [CntW-1:0] cnt_q;

  assign tick = (cnt_q == CntW'(Quarter - 1)) && !clear;

  always_ff @(posedge clk50M or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      phase <= '0;
    end else if (clear) begin
      cnt_q <= '0;
      phase <= '0;
    end else if (tick) begin
      cnt_q <= '0;
      phase <= phase + 2'd1;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/iic.sv
// Single-register I2C master: one register write or read per request, then a one-clock done pulse.
module iic
  import iic_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned SCL_FREQ = 100_000
) (
  input  logic       clk50M,
  input  logic       reset,
  input  logic       iic_en,
  input  logic [2:0] cs_bit,
  input  logic [7:0] address,
  input  logic       write,
  input  logic [7:0] write_data,
  input  logic       read,
  output logic [7:0] read_data,
  output logic       scl,
  inout  wire        sda,
  output logic       done
);

  localparam int unsigned Quarter = CLK_FREQ / (4 * SCL_FREQ);

  iic_state_e state_q;
  logic       tick;
  logic [1:0] phase;
  logic       slot_end, sample;
  logic       op_read_q, nack_q, rx_ok_q, sda_oe_q;
  logic [2:0] cs_q;
  logic [7:0] addr_q, wdata_q, shift_q;
  logic [3:0] bit_cnt_q;
  logic [1:0] byte_idx_q;
  logic       scl_d, sda_oe_d;

  iic_clk_div #(
    .Quarter(Quarter)
  ) u_clk_div (
    .clk50M(clk50M),
    .reset (reset),
    .clear (state_q == StIdle),
    .tick  (tick),
    .phase (phase)
  );

  assign slot_end = tick && (phase == 2'd3);
  assign sample   = tick && (phase == 2'd2);

  // Open-drain: only ever pull low.
  assign sda = sda_oe_q ? 1'b0 : 1'bz;

  // Bus levels for the current state and quarter; registered below.
  always_comb begin
    scl_d    = 1'b1;
    sda_oe_d = 1'b0;
    case (state_q)
      StStart: begin
        scl_d    = (phase != 2'd3);
        sda_oe_d = (phase != 2'd0);
      end
      StTxByte: begin
        scl_d    = phase[1];
        sda_oe_d = !shift_q[7];
      end
      StRxAck, StRxByte, StTxNack: scl_d = phase[1];
      StRestart: begin
        // First slot raises SCL with sda released, second is a plain START.
        if (bit_cnt_q == 4'd0) begin
          scl_d = phase[1];
        end else begin
          scl_d    = (phase != 2'd3);
          sda_oe_d = (phase != 2'd0);
        end
      end
      StStop: begin
        scl_d    = phase[1];
        sda_oe_d = (phase != 2'd3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk50M or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      scl        <= 1'b1;
      sda_oe_q   <= 1'b0;
      done       <= 1'b0;
      read_data  <= 8'h00;
      op_read_q  <= 1'b0;
      nack_q     <= 1'b0;
      rx_ok_q    <= 1'b0;
      cs_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      byte_idx_q <= '0;
    end else begin
      scl      <= scl_d;
      sda_oe_q <= sda_oe_d;
      done     <= 1'b0;
      case (state_q)
        StIdle: begin
          if (iic_en && (write || read)) begin
            op_read_q  <= !write;
            cs_q       <= cs_bit;
            addr_q     <= address;
            wdata_q    <= write_data;
            shift_q    <= {SlavePrefix, cs_bit, RwWrite};
            bit_cnt_q  <= '0;
            byte_idx_q <= '0;
            rx_ok_q    <= 1'b0;
            state_q    <= StStart;
          end
        end
        StStart: if (slot_end) state_q <= StTxByte;
        StTxByte: begin
          if (slot_end) begin
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_q <= '0;
              state_q   <= StRxAck;
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
              shift_q   <= {shift_q[6:0], 1'b0};
            end
          end
        end
        StRxAck: begin
          if (sample) nack_q <= sda;
          if (slot_end) begin
            byte_idx_q <= byte_idx_q + 2'd1;
            if (nack_q) begin
              state_q <= StStop;
            end else begin
              case (byte_idx_q)
                2'd0: begin
                  shift_q <= addr_q;
                  state_q <= StTxByte;
                end
                2'd1: begin
                  if (op_read_q) begin
                    state_q <= StRestart;
                  end else begin
                    shift_q <= wdata_q;
                    state_q <= StTxByte;
                  end
                end
                default: state_q <= op_read_q ? StRxByte : StStop;
              endcase
            end
          end
        end
        StRestart: begin
          if (slot_end) begin
            if (bit_cnt_q == 4'd0) begin
              bit_cnt_q <= 4'd1;
            end else begin
              bit_cnt_q <= '0;
              shift_q   <= {SlavePrefix, cs_q, RwRead};
              state_q   <= StTxByte;
            end
          end
        end
        StRxByte: begin
          if (sample) shift_q <= {shift_q[6:0], sda};
          if (slot_end) begin
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_q <= '0;
              state_q   <= StTxNack;
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end
        end
        StTxNack: begin
          if (slot_end) begin
            rx_ok_q <= 1'b1;
            state_q <= StStop;
          end
        end
        StStop: begin
          if (slot_end) begin
            done    <= 1'b1;
            state_q <= StDone;
            if (rx_ok_q) read_data <= shift_q;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_iic.sv
// Directed bench for iic with a small I2C slave model that logs bus events.
module tb_iic;

  localparam int EvStart = 256;
  localparam int EvStop  = 257;
  localparam int WrLat   = 14500;
  localparam int RdLat   = 20000;

  logic       clk50M;
  logic       reset;
  logic       iic_en;
  logic [2:0] cs_bit;
  logic [7:0] address;
  logic       write;
  logic [7:0] write_data;
  logic       read;
  logic [7:0] read_data;
  logic       scl;
  wire        sda;
  logic       done;

  logic       slv_low;
  logic       nack_first;
  logic       mst_ack_bit;
  logic [7:0] txd;
  int         log_q[$];
  int         done_cnt;
  int         scl_falls;
  int         checks;
  int         errors;

  iic dut (
    .clk50M    (clk50M),
    .reset     (reset),
    .iic_en    (iic_en),
    .cs_bit    (cs_bit),
    .address   (address),
    .write     (write),
    .write_data(write_data),
    .read      (read),
    .read_data (read_data),
    .scl       (scl),
    .sda       (sda),
    .done      (done)
  );

  assign sda = slv_low ? 1'b0 : 1'bz;
  pullup (sda);

  initial clk50M = 1'b0;
  always #10 clk50M = ~clk50M;

  // Slave at 0x68: ACKs written bytes (optionally NACKs the first), returns txd on reads.
  initial begin : slave_model
    logic ps, pd, cs, cd, first_byte, was_addr, rw, ftx;
    logic [7:0] sh;
    int bitpos;
    ps = 1'b1; pd = 1'b1; first_byte = 1'b0; was_addr = 1'b0; rw = 1'b0; ftx = 1'b0;
    sh = '0; bitpos = 0; slv_low = 1'b0; done_cnt = 0; scl_falls = 0; mst_ack_bit = 1'b0;
    forever begin
      @(negedge clk50M);
      cs = scl;
      cd = sda;
      if (done === 1'b1) done_cnt++;
      if (ps && !cs) scl_falls++;
      if (!reset) begin
        slv_low = 1'b0;
        ftx     = 1'b0;
        bitpos  = 0;
      end else if (ps && cs && pd && !cd) begin
        log_q.push_back(EvStart);
        bitpos     = -1;
        first_byte = 1'b1;
        ftx        = 1'b0;
      end else if (ps && cs && !pd && cd) begin
        log_q.push_back(EvStop);
        ftx     = 1'b0;
        slv_low = 1'b0;
      end else if (!ps && cs) begin
        if (bitpos >= 0 && bitpos < 8 && !ftx) sh = {sh[6:0], cd};
        if (bitpos == 8 && ftx) mst_ack_bit = cd;
      end else if (ps && !cs) begin
        bitpos++;
        if (bitpos == 8) begin
          if (ftx) begin
            slv_low = 1'b0;
          end else begin
            log_q.push_back(int'(sh));
            if (first_byte) rw = sh[0];
            slv_low    = !(nack_first && first_byte);
            was_addr   = first_byte;
            first_byte = 1'b0;
          end
        end else if (bitpos == 9) begin
          bitpos  = 0;
          slv_low = 1'b0;
          if (ftx && mst_ack_bit) ftx = 1'b0;
          else if (!ftx && was_addr && rw) ftx = 1'b1;
          was_addr = 1'b0;
          if (ftx) slv_low = !txd[7];
        end else if (ftx && bitpos >= 1 && bitpos <= 7) begin
          slv_low = !txd[7-bitpos];
        end
      end
      ps = cs;
      pd = cd;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    checks++;
    assert (obs >= lo && obs <= hi)
    else begin
      errors++;
      $error("FAIL %s: observed %0d required %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic check_log(input string tag, input int n, input int e[10]);
    check({tag, "_len"}, log_q.size(), n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_%0d", tag, i), (i < log_q.size()) ? log_q[i] : -1, e[i]);
    end
  endtask

  // Counts clock edges until done is seen (sampled #1 after each edge).
  task automatic wait_done(input int budget, output int n);
    n = 0;
    do begin
      @(posedge clk50M);
      #1;
      n++;
    end while (done !== 1'b1 && n < budget);
    check("done_seen", done, 1);
  endtask

  task automatic step(input int cycles);
    repeat (cycles) @(posedge clk50M);
    #1;
  endtask

  initial begin : stimulus
    int n, d0, f0;
    int ev[10];
    checks = 0; errors = 0;
    reset = 1'b0; iic_en = 1'b0; cs_bit = 3'b000; address = 8'h00;
    write = 1'b0; read = 1'b0; write_data = 8'h00; nack_first = 1'b0; txd = 8'h68;

    step(5);
    check("rst_scl", scl, 1);
    check("rst_sda", sda, 1);
    check("rst_done", done, 0);
    check("rst_rdata", read_data, 8'h00);
    reset = 1'b1;
    step(5);

    // Write 0x6B <- 0x80
    log_q.delete(); d0 = done_cnt;
    address = 8'h6B; write_data = 8'h80; write = 1'b1; iic_en = 1'b1;
    wait_done(16000, n);
    check_range("wr_latency", n - 1, WrLat - 2, WrLat + 2);
    iic_en = 1'b0; write = 1'b0;
    step(20);
    ev = '{EvStart, 'hD0, 'h6B, 'h80, EvStop, 0, 0, 0, 0, 0};
    check_log("wr_bus", 5, ev);
    check("wr_done_once", done_cnt - d0, 1);

    // Read 0x75, slave returns 0x68
    log_q.delete(); d0 = done_cnt; mst_ack_bit = 1'b0;
    address = 8'h75; read = 1'b1; iic_en = 1'b1;
    wait_done(21000, n);
    check_range("rd_latency", n - 1, RdLat - 2, RdLat + 2);
    check("rd_data", read_data, 8'h68);
    iic_en = 1'b0; read = 1'b0;
    step(20);
    ev = '{EvStart, 'hD0, 'h75, EvStart, 'hD1, EvStop, 0, 0, 0, 0};
    check_log("rd_bus", 6, ev);
    check("rd_master_nack", mst_ack_bit, 1);
    check("rd_done_once", done_cnt - d0, 1);

    // Back-to-back with write and read both set; new operands appear in the done cycle
    log_q.delete(); d0 = done_cnt;
    address = 8'h1B; write_data = 8'h18; write = 1'b1; read = 1'b1; iic_en = 1'b1;
    wait_done(16000, n);
    address = 8'h1C; write_data = 8'h00;
    wait_done(16000, n);
    check_range("b2b_gap", n, WrLat, WrLat + 4);
    iic_en = 1'b0; write = 1'b0; read = 1'b0;
    step(20);
    ev = '{EvStart, 'hD0, 'h1B, 'h18, EvStop, EvStart, 'hD0, 'h1C, 'h00, EvStop};
    check_log("b2b_bus", 10, ev);
    check("b2b_done_twice", done_cnt - d0, 2);
    check("b2b_rdata_kept", read_data, 8'h68);

    // Slave NACKs the address byte of a read
    log_q.delete(); d0 = done_cnt; nack_first = 1'b1;
    address = 8'h3B; read = 1'b1; iic_en = 1'b1;
    wait_done(8000, n);
    check("nack_rdata_kept", read_data, 8'h68);
    iic_en = 1'b0; read = 1'b0;
    step(20);
    nack_first = 1'b0;
    ev = '{EvStart, 'hD0, EvStop, 0, 0, 0, 0, 0, 0, 0};
    check_log("nack_bus", 3, ev);
    check("nack_done_once", done_cnt - d0, 1);

    // Enable with no operation selected
    log_q.delete(); d0 = done_cnt; f0 = scl_falls;
    iic_en = 1'b1;
    step(1000);
    check("noop_scl_idle", scl_falls - f0, 0);
    check("noop_no_done", done_cnt - d0, 0);
    check("noop_bus_quiet", log_q.size(), 0);
    iic_en = 1'b0;
    step(5);

    // Reset during the data byte of a write
    log_q.delete(); d0 = done_cnt;
    address = 8'h6B; write_data = 8'h55; write = 1'b1; iic_en = 1'b1;
    step(10250);
    reset = 1'b0; iic_en = 1'b0; write = 1'b0;
    #1;
    check("mid_rst_scl", scl, 1);
    check("mid_rst_sda", sda, 1);
    check("mid_rst_done", done, 0);
    check("mid_rst_rdata", read_data, 8'h00);
    step(5);
    reset = 1'b1;
    step(20);
    check("mid_rst_no_done", done_cnt - d0, 0);
    ev = '{EvStart, 'hD0, 'h6B, 0, 0, 0, 0, 0, 0, 0};
    check_log("mid_rst_bus", 3, ev);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
